// File: rtl/avmm_pkg.sv
// Shared types and default parameters for the Avalon-MM read responder.
package avmm_pkg;

    localparam int DEF_ADDR_WIDTH   = 32;
    localparam int DEF_DATA_WIDTH   = 64;
    localparam int DEF_DEPTH        = 16;
    localparam int DEF_READ_LATENCY = 4;
    localparam int DEF_MAX_PENDING  = 4;

    // Response service FSM: wait for a queued request, count out the latency, return data.
    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } rsp_state_t;

    typedef logic [DEF_ADDR_WIDTH-1:0] word_addr_t;

endpackage

// File: rtl/avmm_req_fifo.sv
// In-order request queue. A push while full is accepted when a pop happens in the same cycle.
module avmm_req_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    // NOTE: storage has no reset; only the pointers and count define what is valid.
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Pointer and occupancy bookkeeping.
    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Queue storage write.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule

// File: rtl/avmm_read_responder.sv
// Avalon-MM pipelined-read slave backed by a preloadable word array.
// Requests are queued in order and served one at a time with a fixed latency.
module avmm_read_responder
    import avmm_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int DEPTH        = DEF_DEPTH,
    parameter int READ_LATENCY = DEF_READ_LATENCY,
    parameter int MAX_PENDING  = DEF_MAX_PENDING
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  read,
    output logic                  waitrequest,
    output logic [DATA_WIDTH-1:0] readdata,
    output logic                  readdatavalid,
    input  logic                  pl_wr,
    input  logic [ADDR_WIDTH-1:0] pl_addr,
    input  logic [DATA_WIDTH-1:0] pl_data,
    output logic                  oor_err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(DEPTH);
    localparam logic [CNT_W-1:0]      CNT_LOAD = CNT_W'(READ_LATENCY - 1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_readdata;
    logic                  r_init_done;
    logic                  r_oor_err;
    rsp_state_t            r_state;
    rsp_state_t            w_next_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_next_cnt;

    logic                  w_accept;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic [ADDR_WIDTH-1:0] w_head_addr;
    logic                  w_head_oor;
    logic                  w_array_rd;

    // Range checks use the full address width; only then is the index truncated.
    assign w_head_oor  = (w_head_addr >= DEPTH_A);
    assign w_pop       = (r_state == RESP);
    assign w_array_rd  = (r_state == WAIT) && (r_cnt == '0);
    assign waitrequest = ~r_init_done | (w_full & ~w_pop);
    assign w_accept    = read & ~waitrequest;

    assign readdata      = r_readdata;
    assign readdatavalid = w_pop;
    assign oor_err       = r_oor_err;

    avmm_req_fifo #(
        .WIDTH (ADDR_WIDTH),
        .DEPTH (MAX_PENDING)
    ) u_req_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_accept),
        .i_push_data (address),
        .i_pop       (w_pop),
        .o_head      (w_head_addr),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    // Hold off requests for the first cycle after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_init_done <= 1'b0;
        else        r_init_done <= 1'b1;
    end

    // Sticky flag for any accepted out-of-range read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                r_oor_err <= 1'b0;
        else if (w_accept && (address >= DEPTH_A)) r_oor_err <= 1'b1;
    end

    // Preload port; out-of-range preload addresses are dropped.
    always_ff @(posedge clk) begin
        if (pl_wr && (pl_addr < DEPTH_A)) r_mem[pl_addr[IDX_W-1:0]] <= pl_data;
    end

    // Capture response data at the end of the latency count; sees the pre-preload value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_readdata <= '0;
        end else if (w_array_rd) begin
            r_readdata <= w_head_oor ? '0 : r_mem[w_head_addr[IDX_W-1:0]];
        end
    end

    // Service FSM state and latency counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Service FSM next-state and counter logic.
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_next_state = WAIT;
                    w_next_cnt   = CNT_LOAD;
                end
            end
            WAIT: begin
                if (r_cnt != '0) w_next_cnt   = r_cnt - CNT_W'(1);
                else             w_next_state = RESP;
            end
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

endmodule
